// File: rtl/pe_pre_pkg.sv
// Shared types and geometry helpers for the padded row streamer.
// All derived widths come from here so every file agrees on them.
package pe_pre_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_BUF = 3'd1,
    S_PAD_ROW  = 3'd2,
    S_FETCH    = 3'd3,
    S_EMIT     = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  function automatic int row_pix(input int w, input int p);
    return w + 2 * p;
  endfunction

  function automatic int out_w(input int dw, input int w, input int p);
    return row_pix(w, p) * dw;
  endfunction

  function automatic int rows(input int h, input int p);
    return h + 2 * p;
  endfunction

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int row_w(input int h, input int p);
    return clog2_min1(rows(h, p));
  endfunction

  function automatic logic is_pad_row(input int r, input int h, input int p);
    return (r < p) || (r >= p + h);
  endfunction

endpackage

// File: rtl/padded_row_streamer_if.sv
// Buffer read port plus padded-row handshake towards the PE array.
// master = streamer side, slave = buffer / PE side.
interface padded_row_streamer_if
  import pe_pre_pkg::*;
#(
  parameter int DW     = 8,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int PAD    = 1,
  parameter int ADDR_W = 16
);

  localparam int OUT_W = out_w(DW, IMG_W, PAD);
  localparam int RW    = row_w(IMG_H, PAD);

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DW-1:0]     rd_data;
  logic [OUT_W-1:0]  row_data;
  logic              row_valid;
  logic              row_ready;
  logic [RW-1:0]     row_idx;

  modport master (
    output rd_en, rd_addr,
    input  rd_data,
    output row_data, row_valid, row_idx,
    input  row_ready
  );

  modport slave (
    input  rd_en, rd_addr,
    output rd_data,
    input  row_data, row_valid, row_idx,
    output row_ready
  );

endinterface

// File: rtl/padded_row_assembler.sv
// ROW_PIX-slot row register: fill every slot with pad, or write one slot.
// Slot 0 sits in the most significant DW bits of the flattened row.
module padded_row_assembler
  import pe_pre_pkg::*;
#(
  parameter int DW      = 8,
  parameter int ROW_PIX = 34,
  parameter int SW      = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fill,
  input  logic                  wr,
  input  logic [SW-1:0]         slot,
  input  logic [DW-1:0]         pad,
  input  logic [DW-1:0]         data,
  output logic [ROW_PIX*DW-1:0] row
);

  logic [DW-1:0] slots_q [ROW_PIX];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < ROW_PIX; k++)
        slots_q[k] <= '0;
    end else begin
      for (int k = 0; k < ROW_PIX; k++) begin
        if (wr && slot == SW'(k))
          slots_q[k] <= data;
        else if (fill)
          slots_q[k] <= pad;
      end
    end
  end

  always_comb begin
    row = '0;
    for (int k = 0; k < ROW_PIX; k++)
      row[ROW_PIX*DW-1-k*DW -: DW] = slots_q[k];
  end

endmodule

// File: rtl/padded_row_streamer.sv
// Streams one buffered frame as padding-framed parallel rows.
// FSM, row/column counters and read addressing live here.
module padded_row_streamer
  import pe_pre_pkg::*;
#(
  parameter int DW     = 8,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int PAD    = 1,
  parameter int ADDR_W = 16
) (
  input  logic                  dout_clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  buf_ready,
  input  logic [DW-1:0]         pad_value,
  padded_row_streamer_if.master bus,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  swap_req
);

  localparam int ROW_PIX = row_pix(IMG_W, PAD);
  localparam int OUT_W   = out_w(DW, IMG_W, PAD);
  localparam int ROWS    = rows(IMG_H, PAD);
  localparam int RW      = row_w(IMG_H, PAD);
  localparam int CW      = clog2_min1(IMG_W + 1);
  localparam int SW      = clog2_min1(ROW_PIX);

  state_t            state_q, state_d;
  logic [RW-1:0]     r_q;
  logic [CW-1:0]     c_q;
  logic [CW-1:0]     cap_col_q;
  logic              cap_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DW-1:0]     pad_q;
  logic [OUT_W-1:0]  row_q;

  logic rd_fire;
  logic fill;
  logic wr;
  logic last;
  logic next_pad;
  logic [SW-1:0] slot;

  assign last     = (r_q == RW'(ROWS - 1));
  assign next_pad = is_pad_row(int'(r_q) + 1, IMG_H, PAD);
  assign slot     = SW'(PAD + int'(cap_col_q));

  always_comb begin
    state_d = state_q;
    rd_fire = 1'b0;
    fill    = 1'b0;
    wr      = 1'b0;
    unique case (state_q)
      S_IDLE:
        if (start) state_d = S_WAIT_BUF;
      S_WAIT_BUF:
        if (buf_ready)
          state_d = (PAD > 0) ? S_PAD_ROW : S_FETCH;
      S_PAD_ROW: begin
        fill    = 1'b1;
        state_d = S_EMIT;
      end
      S_FETCH: begin
        // slot writes lag reads by one cycle; the extra cycle drains the last
        fill    = (c_q == '0);
        rd_fire = (c_q < CW'(IMG_W));
        wr      = cap_q;
        if (c_q == CW'(IMG_W)) state_d = S_EMIT;
      end
      S_EMIT:
        if (bus.row_ready) begin
          if (last)          state_d = S_DONE;
          else if (next_pad) state_d = S_PAD_ROW;
          else               state_d = S_FETCH;
        end
      S_DONE:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  // image rows are read in order, so the address is just a read count
  always_ff @(posedge dout_clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      r_q       <= '0;
      c_q       <= '0;
      cap_q     <= 1'b0;
      cap_col_q <= '0;
      addr_q    <= '0;
      pad_q     <= '0;
    end else begin
      state_q   <= state_d;
      cap_q     <= rd_fire;
      cap_col_q <= c_q;
      if (state_q == S_IDLE && start) begin
        pad_q  <= pad_value;
        r_q    <= '0;
        addr_q <= '0;
      end
      if (rd_fire)
        addr_q <= addr_q + ADDR_W'(1);
      if (state_q == S_FETCH)
        c_q <= (c_q == CW'(IMG_W)) ? '0 : c_q + CW'(1);
      if (state_q == S_EMIT && bus.row_ready && !last)
        r_q <= r_q + RW'(1);
    end
  end

  padded_row_assembler #(
    .DW      (DW),
    .ROW_PIX (ROW_PIX),
    .SW      (SW)
  ) u_asm (
    .clk   (dout_clk),
    .rst_n (rst_n),
    .fill  (fill),
    .wr    (wr),
    .slot  (slot),
    .pad   (pad_q),
    .data  (bus.rd_data),
    .row   (row_q)
  );

  assign bus.rd_en     = rd_fire;
  assign bus.rd_addr   = addr_q;
  assign bus.row_data  = row_q;
  assign bus.row_valid = (state_q == S_EMIT);
  assign bus.row_idx   = r_q;
  assign busy          = (state_q != S_IDLE);
  assign frame_done    = (state_q == S_DONE);
  assign swap_req      = (state_q == S_DONE);

endmodule

// File: tb/tb_padded_row_streamer.sv
// Directed bench: 4x3/PAD=1 and 2x2/PAD=0 streamers with addr-echo buffers.
// Rows are collected at negedges and compared against hand values.
module tb_padded_row_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       start_a, buf_ready_a;
  logic [7:0] pad_a;
  logic       busy_a, done_a, swap_a;
  logic       start_b, buf_ready_b;
  logic [7:0] pad_b;
  logic       busy_b, done_b, swap_b;

  padded_row_streamer_if #(
    .DW(8), .IMG_W(4), .IMG_H(3), .PAD(1), .ADDR_W(16)
  ) bus_a ();

  padded_row_streamer_if #(
    .DW(8), .IMG_W(2), .IMG_H(2), .PAD(0), .ADDR_W(16)
  ) bus_b ();

  padded_row_streamer #(
    .DW(8), .IMG_W(4), .IMG_H(3), .PAD(1), .ADDR_W(16)
  ) dut_a (
    .dout_clk   (clk),
    .rst_n      (rst_n),
    .start      (start_a),
    .buf_ready  (buf_ready_a),
    .pad_value  (pad_a),
    .bus        (bus_a),
    .busy       (busy_a),
    .frame_done (done_a),
    .swap_req   (swap_a)
  );

  padded_row_streamer #(
    .DW(8), .IMG_W(2), .IMG_H(2), .PAD(0), .ADDR_W(16)
  ) dut_b (
    .dout_clk   (clk),
    .rst_n      (rst_n),
    .start      (start_b),
    .buf_ready  (buf_ready_b),
    .pad_value  (pad_b),
    .bus        (bus_b),
    .busy       (busy_b),
    .frame_done (done_b),
    .swap_req   (swap_b)
  );

  always @(posedge clk) begin
    if (bus_a.rd_en) bus_a.rd_data <= bus_a.rd_addr[7:0];
    if (bus_b.rd_en) bus_b.rd_data <= bus_b.rd_addr[7:0];
  end

  int cyc;
  int dn_a, sw_bad_a, rd_a, last_dn_a;
  int dn_b, sw_bad_b, rd_b, last_dn_b;
  logic [63:0] rows_a[$];
  int          idx_a[$];
  logic [63:0] rows_b[$];
  int          idx_b[$];

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (bus_a.row_valid && bus_a.row_ready) begin
        rows_a.push_back(64'(bus_a.row_data));
        idx_a.push_back(int'(bus_a.row_idx));
      end
      if (done_a) begin dn_a++; last_dn_a = cyc; end
      if (done_a != swap_a) sw_bad_a++;
      if (bus_a.rd_en) rd_a++;
      if (bus_b.row_valid && bus_b.row_ready) begin
        rows_b.push_back(64'(bus_b.row_data));
        idx_b.push_back(int'(bus_b.row_idx));
      end
      if (done_b) begin dn_b++; last_dn_b = cyc; end
      if (done_b != swap_b) sw_bad_b++;
      if (bus_b.rd_en) rd_b++;
    end
  end

  int checks, errors;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [47:0] exp_a(input int r, input logic [7:0] p);
    logic [47:0] v;
    v = {6{p}};
    if (r >= 1 && r <= 3)
      for (int k = 0; k < 4; k++)
        v[39-8*k -: 8] = 8'((r - 1) * 4 + k);
    return v;
  endfunction

  task automatic pulse_a(input logic [7:0] p, output int s0);
    pad_a = p; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    s0 = cyc;
  endtask

  task automatic wait_done_a(input string tag);
    int b = dn_a;
    int n = 0;
    while (dn_a == b && n < 200) begin tick(); n++; end
    chk({tag, "_timeout"}, 64'(dn_a != b), 1);
  endtask

  task automatic check_rows_a(input string tag, input int base,
                              input logic [7:0] p);
    chk({tag, "_nrows"}, 64'(rows_a.size() - base), 5);
    for (int i = 0; i < 5; i++)
      if (base + i < rows_a.size()) begin
        chk($sformatf("%s_row%0d", tag, i), rows_a[base+i], exp_a(i, p));
        chk($sformatf("%s_idx%0d", tag, i), 64'(idx_a[base+i]), 64'(i));
      end
  endtask

  task automatic check_reset_a(input string tag);
    chk({tag, "_rd_en"}, 64'(bus_a.rd_en), 0);
    chk({tag, "_rd_addr"}, 64'(bus_a.rd_addr), 0);
    chk({tag, "_row_data"}, 64'(bus_a.row_data), 0);
    chk({tag, "_row_valid"}, 64'(bus_a.row_valid), 0);
    chk({tag, "_row_idx"}, 64'(bus_a.row_idx), 0);
    chk({tag, "_busy"}, 64'(busy_a), 0);
    chk({tag, "_done"}, 64'(done_a), 0);
    chk({tag, "_swap"}, 64'(swap_a), 0);
  endtask

  initial begin
    int s0, base, n, rd0, d0;
    rst_n = 1'b0;
    start_a = 1'b0; buf_ready_a = 1'b1; pad_a = 8'h00;
    start_b = 1'b0; buf_ready_b = 1'b1; pad_b = 8'h00;
    bus_a.row_ready = 1'b1;
    bus_b.row_ready = 1'b1;
    tick(3);
    check_reset_a("rst_a");
    chk("rst_b_row_data", 64'(bus_b.row_data), 0);
    chk("rst_b_busy", 64'(busy_b), 0);
    rst_n = 1'b1;
    tick();

    // basic frame, pad 0xAA
    base = rows_a.size();
    rd0 = rd_a;
    pulse_a(8'hAA, s0);
    wait_done_a("f1");
    check_rows_a("f1", base, 8'hAA);
    if (rows_a.size() >= base + 5) begin
      chk("f1_lit0", rows_a[base], 64'h0000AAAAAAAAAAAA);
      chk("f1_lit1", rows_a[base+1], 64'h0000AA00010203AA);
      chk("f1_lit3", rows_a[base+3], 64'h0000AA08090A0BAA);
    end
    chk("f1_len", 64'(last_dn_a - s0), 24);
    chk("f1_reads", 64'(rd_a - rd0), 12);
    chk("f1_swap_align", 64'(sw_bad_a), 0);
    chk("f1_done_cnt", 64'(dn_a), 1);
    chk("f1_busy_after", 64'(busy_a), 0);

    // stall row 2 for five cycles
    base = rows_a.size();
    pulse_a(8'hAA, s0);
    n = 0;
    while (!(bus_a.rd_en && bus_a.rd_addr == 16'd4) && n < 50) begin
      tick(); n++;
    end
    chk("stall_seek", 64'(n < 50), 1);
    bus_a.row_ready = 1'b0;
    n = 0;
    while (!bus_a.row_valid && n < 50) begin tick(); n++; end
    chk("stall_valid", 64'(n < 50), 1);
    rd0 = rd_a;
    for (int i = 0; i < 5; i++) begin
      chk("stall_data", 64'(bus_a.row_data), 64'h0000AA04050607AA);
      chk("stall_idx", 64'(bus_a.row_idx), 2);
      tick();
    end
    chk("stall_reads", 64'(rd_a - rd0), 0);
    bus_a.row_ready = 1'b1;
    wait_done_a("stall");
    check_rows_a("stall", base, 8'hAA);
    chk("stall_len", 64'(last_dn_a - s0), 29);

    // buffer not ready for ten cycles
    base = rows_a.size();
    buf_ready_a = 1'b0;
    rd0 = rd_a;
    pulse_a(8'hAA, s0);
    tick(9);
    chk("nobuf_busy", 64'(busy_a), 1);
    chk("nobuf_valid", 64'(bus_a.row_valid), 0);
    tick();
    chk("nobuf_reads", 64'(rd_a - rd0), 0);
    buf_ready_a = 1'b1;
    wait_done_a("nobuf");
    check_rows_a("nobuf", base, 8'hAA);
    chk("nobuf_len", 64'(last_dn_a - s0), 34);

    // restart attempt and pad change mid-frame are ignored
    base = rows_a.size();
    d0 = dn_a;
    pulse_a(8'h3C, s0);
    tick(3);
    pad_a = 8'h55;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_done_a("mid");
    check_rows_a("mid", base, 8'h3C);
    chk("mid_len", 64'(last_dn_a - s0), 24);
    tick(3);
    chk("mid_busy_after", 64'(busy_a), 0);
    chk("mid_done_cnt", 64'(dn_a - d0), 1);

    // reset during fetch of row 2
    pulse_a(8'hAA, s0);
    n = 0;
    while (!(bus_a.rd_en && bus_a.rd_addr == 16'd5) && n < 50) begin
      tick(); n++;
    end
    chk("rst_seek", 64'(n < 50), 1);
    d0 = dn_a;
    rst_n = 1'b0;
    tick();
    check_reset_a("midrst");
    tick(2);
    rst_n = 1'b1;
    tick();
    chk("midrst_no_done", 64'(dn_a - d0), 0);
    base = rows_a.size();
    pulse_a(8'hAA, s0);
    wait_done_a("post");
    check_rows_a("post", base, 8'hAA);
    chk("post_len", 64'(last_dn_a - s0), 24);
    chk("swap_align_all", 64'(sw_bad_a), 0);

    // no padding, 2x2 image
    rd0 = rd_b;
    pad_b = 8'h77;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    s0 = cyc;
    n = 0;
    while (dn_b == 0 && n < 100) begin tick(); n++; end
    chk("b_timeout", 64'(dn_b != 0), 1);
    chk("b_nrows", 64'(rows_b.size()), 2);
    if (rows_b.size() >= 2) begin
      chk("b_row0", rows_b[0], 64'h0001);
      chk("b_row1", rows_b[1], 64'h0203);
      chk("b_idx1", 64'(idx_b[1]), 1);
    end
    chk("b_len", 64'(last_dn_b - s0), 10);
    chk("b_reads", 64'(rd_b - rd0), 4);
    chk("b_swap_align", 64'(sw_bad_b), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/padded_row_streamer.md
# padded_row_streamer

Parametrised successor to the PE input pre-data stage. Reads one frame from the ping-pong input buffer's read port and emits it as zero-skew, padding-framed parallel rows to the PE array, one row per valid/ready handshake. Generalised in pixel width, image size and padding depth. Adds explicit handshaking, frame sequencing and a buffer-swap request that the previous generation lacked. Sits between `PingPongBuffer` and the PE row inputs, in the `dout_clk` domain.

## Interface
- `DW`, 8, pixel width in bits
- `IMG_W`, 32, pixels per image row (≥1)
- `IMG_H`, 32, image rows (≥1)
- `PAD`, 1, padding depth in pixels on every side (0..4)
- `ADDR_W`, 16, buffer read-address width; `IMG_W*IMG_H` must fit
- Derived, not overridable: `ROW_PIX = IMG_W+2*PAD`, `OUT_W = ROW_PIX*DW`, `ROWS = IMG_H+2*PAD`, `RW = $clog2(ROWS)` (min 1)

Ports:
- `dout_clk`  in  1  single clock, all logic on its rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  frame request pulse; ignored unless idle
- `buf_ready`  in  1  buffer holds a complete frame
- `pad_value`  in  DW  padding pixel; latched on accepted `start`
- `rd_en`  out  1  buffer read strobe
- `rd_addr`  out  ADDR_W  buffer read address
- `rd_data`  in  DW  read data, valid exactly 1 cycle after `rd_en`
- `row_data`  out  OUT_W  padded row; slot 0 in `[OUT_W-1 -: DW]`, slot k in `[OUT_W-1-k*DW -: DW]`
- `row_valid`  out  1  `row_data` valid
- `row_ready`  in  1  PE side accepts row
- `row_idx`  out  RW  index (0..ROWS-1) of row on `row_data`
- `busy`  out  1  high from accepted `start` until `frame_done` inclusive
- `frame_done`  out  1  one-cycle pulse after last row accepted
- `swap_req`  out  1  one-cycle pulse coincident with `frame_done`; drives ping-pong switch

## Operation
- FSM states: IDLE, WAIT_BUF, PAD_ROW, FETCH, EMIT, DONE.
- IDLE: `start`=1 → latch `pad_value`, clear row counter, go to WAIT_BUF.
- WAIT_BUF: stay while `buf_ready`=0. When `buf_ready`=1, go to PAD_ROW if row 0 is a pad row (PAD>0), else FETCH.
- Row r is a pad row iff r<PAD or r≥PAD+IMG_H.
- PAD_ROW (1 cycle): all ROW_PIX slots ← latched pad, then go to EMIT.
- FETCH: column counter c=0..IMG_W-1. Issue `rd_en`=1 with `rd_addr=(r-PAD)*IMG_W+c`, one per cycle. Data returned for column c is written to slot PAD+c on the following cycle. Slots 0..PAD-1 and PAD+IMG_W..ROW_PIX-1 ← latched pad. Leave FETCH after the last capture.
- EMIT: `row_valid`=1, with `row_data` and `row_idx` held stable until `row_ready`. On handshake: if r=ROWS-1 go to DONE; else r←r+1 and go to PAD_ROW or FETCH per the rule above.
- DONE (1 cycle): `frame_done`=`swap_req`=1, then go to IDLE.
- `start` outside IDLE is ignored; `buf_ready` is sampled only in WAIT_BUF.
- Address arithmetic is unsigned in ADDR_W bits; never wraps for legal parameters.

## Timing
- Reset values: `rd_en`=0, `rd_addr`=0, `row_data`=0, `row_valid`=0, `row_idx`=0, `busy`=0, `frame_done`=0, `swap_req`=0; state IDLE. Latched pad resets to 0.
- Reset mid-frame: all of the above take effect on the next edge. Any read in flight is discarded and no pulse is emitted.
- Pad row: EMIT is entered 1 cycle after entering PAD_ROW.
- Image row: FETCH lasts IMG_W+1 cycles, then EMIT.
- Minimum frame time, with `buf_ready` and `row_ready` always high: 1 (WAIT_BUF) + 2·PAD·2 + IMG_H·(IMG_W+2) + 1 (DONE) cycles after the `start` edge.
- `row_valid` is never deasserted without a handshake. `row_ready` without `row_valid` has no effect.
- `rd_en` is asserted only in FETCH and only for c<IMG_W.

## Structure
- Package `pe_pre_pkg`: state enum, helpers for the derived localparams (`ROW_PIX`, `OUT_W`, `ROWS`) and the pad-row predicate.
- One sub-module, `padded_row_assembler`: the ROW_PIX-slot register with fill-all-pad and write-slot operations. The FSM, counters and address generation stay in the top.

## Test plan
- DW=8, IMG_W=4, IMG_H=3, PAD=1, pad 0xAA, `rd_data`=addr[7:0], `row_ready`=1 → 5 rows: row0 = six 0xAA; row1 = AA,00,01,02,03,AA; row2 = AA,04..07,AA; row3 = AA,08..0B,AA; row4 = six 0xAA. `frame_done` and `swap_req` pulse once, on the same cycle.
- Same configuration, `row_ready` low for 5 cycles in row 2 → `row_data`/`row_idx`=2 held unchanged; no reads issued while stalled.
- PAD=0, IMG_W=2, IMG_H=2 → 2 rows 00,01 / 02,03; no PAD_ROW visits.
- `buf_ready`=0 for 10 cycles after `start` → no `rd_en`, `busy`=1; frame proceeds once `buf_ready`=1.
- `start` pulsed mid-frame, and `pad_value` changed mid-frame → no effect; rows use the pad latched at the accepted `start`.
- `rst_n`=0 during FETCH of row 2 → next edge: all outputs at reset values; a following `start` produces a complete correct frame.
